// File: rtl/alu_muldiv_if.sv
// Handshake and data bundle between the issue stage and the execute-stage ALU.
// The master side issues operations and consumes results; the slave side is the ALU.
interface alu_muldiv_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 5
) ();
    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_WIDTH-1:0]    SrcA;
    logic [DATA_WIDTH-1:0]    SrcB;
    logic [OPCODE_LENGTH-1:0] Operation;
    logic                     flush;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    ALUResult;
    logic                     Zero;
    logic                     busy;

    modport master (
        output in_valid, SrcA, SrcB, Operation, flush, out_ready,
        input  in_ready, out_valid, ALUResult, Zero, busy
    );

    modport slave (
        input  in_valid, SrcA, SrcB, Operation, flush, out_ready,
        output in_ready, out_valid, ALUResult, Zero, busy
    );
endinterface

// File: rtl/alu_muldiv.sv
// Execute-stage ALU: single-cycle base integer ops plus the RISC-V M extension
// on an iterative radix-2 shift-add / restoring-divide datapath.
module alu_muldiv #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 5
) (
    input  logic          clk,
    input  logic          reset_n,
    alu_muldiv_if.slave   bus
);
    localparam int W  = DATA_WIDTH;
    localparam int SW = $clog2(DATA_WIDTH);

    typedef logic [OPCODE_LENGTH-1:0] op_t;
    localparam op_t OP_AND  = op_t'(5'b00000);
    localparam op_t OP_OR   = op_t'(5'b00001);
    localparam op_t OP_XOR  = op_t'(5'b00010);
    localparam op_t OP_SRA  = op_t'(5'b00011);
    localparam op_t OP_ADD  = op_t'(5'b00100);
    localparam op_t OP_SUB  = op_t'(5'b00101);
    localparam op_t OP_SLL  = op_t'(5'b00110);
    localparam op_t OP_SRL  = op_t'(5'b00111);
    localparam op_t OP_EQ   = op_t'(5'b01000);
    localparam op_t OP_NE   = op_t'(5'b01001);
    localparam op_t OP_SLT  = op_t'(5'b01010);
    localparam op_t OP_SLTU = op_t'(5'b01011);
    localparam op_t OP_MUL  = op_t'(5'b10000);
    localparam op_t OP_REMU = op_t'(5'b10111);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state, state_d;
    logic [SW-1:0]   cnt;
    logic [2*W-1:0]  acc;
    logic [W-1:0]    divisor;
    logic            is_div_q, rem_q, high_q, neg_q;
    logic [W-1:0]    result;

    logic            accept, is_m, special, go_long;
    logic            a_signed, b_signed, neg_a, neg_b, div_zero, div_ovf;
    logic [2:0]      mop;
    logic [W-1:0]    mag_a, mag_b, base_res, quick;
    logic [SW-1:0]   shamt;
    logic [W:0]      mul_sum, div_shift;
    logic [W-1:0]    div_diff, div_val;
    logic [2*W-1:0]  step_acc, prod;
    logic [W-1:0]    fix_res;

    assign bus.in_ready  = ((state == IDLE) || (state == DONE && bus.out_ready))
                           && !bus.flush && reset_n;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state == CALC) || (state == FIX);
    assign bus.ALUResult = result;
    assign bus.Zero      = (result == '0);

    // Decode the incoming operation, form operand magnitudes and the one-cycle result.
    always_comb begin
        mop      = bus.Operation[2:0];
        shamt    = bus.SrcB[SW-1:0];
        is_m     = (bus.Operation >= OP_MUL) && (bus.Operation <= OP_REMU);
        a_signed = is_m && (mop == 3'b001 || mop == 3'b010 || mop == 3'b100 || mop == 3'b110);
        b_signed = is_m && (mop == 3'b001 || mop == 3'b100 || mop == 3'b110);
        neg_a    = a_signed && bus.SrcA[W-1];
        neg_b    = b_signed && bus.SrcB[W-1];
        mag_a    = neg_a ? -bus.SrcA : bus.SrcA;
        mag_b    = neg_b ? -bus.SrcB : bus.SrcB;
        div_zero = is_m && mop[2] && (bus.SrcB == '0);
        div_ovf  = is_m && (mop == 3'b100 || mop == 3'b110)
                   && (bus.SrcA == {1'b1, {(W-1){1'b0}}}) && (bus.SrcB == '1);
        special  = div_zero || div_ovf;
        go_long  = is_m && !special;

        base_res = '0;
        case (bus.Operation)
            OP_AND:  base_res = bus.SrcA & bus.SrcB;
            OP_OR:   base_res = bus.SrcA | bus.SrcB;
            OP_XOR:  base_res = bus.SrcA ^ bus.SrcB;
            OP_ADD:  base_res = bus.SrcA + bus.SrcB;
            OP_SUB:  base_res = bus.SrcA - bus.SrcB;
            OP_SLL:  base_res = bus.SrcA << shamt;
            OP_SRL:  base_res = bus.SrcA >> shamt;
            OP_SRA:  base_res = $unsigned($signed(bus.SrcA) >>> shamt);
            OP_EQ:   base_res = {{(W-1){1'b0}}, bus.SrcA == bus.SrcB};
            OP_NE:   base_res = {{(W-1){1'b0}}, bus.SrcA != bus.SrcB};
            OP_SLT:  base_res = {{(W-1){1'b0}}, $signed(bus.SrcA) < $signed(bus.SrcB)};
            OP_SLTU: base_res = {{(W-1){1'b0}}, bus.SrcA < bus.SrcB};
            default: base_res = '0;
        endcase

        if (div_zero)
            quick = mop[1] ? bus.SrcA : '1;
        else if (div_ovf)
            quick = mop[1] ? '0 : bus.SrcA;
        else
            quick = base_res;
    end

    // One iteration step and the final sign correction of the multi-cycle datapath.
    always_comb begin
        mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, divisor} : '0);
        div_shift = {acc[2*W-1:W], acc[W-1]};
        div_diff  = div_shift[W-1:0] - divisor;
        if (!is_div_q)
            step_acc = {mul_sum, acc[W-1:1]};
        else if (div_shift >= {1'b0, divisor})
            step_acc = {div_diff, acc[W-2:0], 1'b1};
        else
            step_acc = {div_shift[W-1:0], acc[W-2:0], 1'b0};

        prod    = neg_q ? -acc : acc;
        div_val = rem_q ? acc[2*W-1:W] : acc[W-1:0];
        if (is_div_q)
            fix_res = neg_q ? -div_val : div_val;
        else
            fix_res = high_q ? prod[2*W-1:W] : prod[W-1:0];
    end

    // Next-state logic; flush overrides everything and returns to IDLE.
    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (accept) state_d = go_long ? CALC : DONE;
            CALC: if (cnt == '0) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: begin
                if (accept)
                    state_d = go_long ? CALC : DONE;
                else if (bus.out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (bus.flush)
            state_d = IDLE;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_d;
    end

    // Datapath registers: load on accept, iterate in CALC, correct signs in FIX.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt      <= '0;
            acc      <= '0;
            divisor  <= '0;
            is_div_q <= 1'b0;
            rem_q    <= 1'b0;
            high_q   <= 1'b0;
            neg_q    <= 1'b0;
            result   <= '0;
        end else if (accept) begin
            if (go_long) begin
                acc      <= {{W{1'b0}}, mag_a};
                divisor  <= mag_b;
                cnt      <= SW'(W - 1);
                is_div_q <= mop[2];
                rem_q    <= mop[2] && mop[1];
                high_q   <= !mop[2] && (mop != 3'b000);
                neg_q    <= (mop[2] && mop[1]) ? neg_a : (neg_a ^ neg_b);
            end else begin
                result <= quick;
            end
        end else if (state == CALC) begin
            cnt <= cnt - SW'(1);
            acc <= step_acc;
        end else if (state == FIX) begin
            result <= fix_res;
        end
    end
endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: a driver pushes model results on accept and
// a monitor pops and compares whenever a result is handed over.
module tb_alu_muldiv;
    localparam int W = 32;
    localparam logic [W-1:0] MINV = 32'h8000_0000;

    localparam logic [4:0] C_AND = 5'b00000, C_OR = 5'b00001, C_XOR = 5'b00010, C_SRA = 5'b00011;
    localparam logic [4:0] C_ADD = 5'b00100, C_SUB = 5'b00101, C_SLL = 5'b00110, C_SRL = 5'b00111;
    localparam logic [4:0] C_EQ = 5'b01000, C_NE = 5'b01001, C_SLT = 5'b01010, C_SLTU = 5'b01011;
    localparam logic [4:0] C_MUL = 5'b10000, C_MULH = 5'b10001, C_MULHSU = 5'b10010, C_MULHU = 5'b10011;
    localparam logic [4:0] C_DIV = 5'b10100, C_DIVU = 5'b10101, C_REM = 5'b10110, C_REMU = 5'b10111;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    alu_muldiv_if #(.DATA_WIDTH(W), .OPCODE_LENGTH(5)) bus ();
    alu_muldiv #(.DATA_WIDTH(W), .OPCODE_LENGTH(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic [W-1:0] res;
        logic [31:0]  lat;
        logic [31:0]  acc_cyc;
        logic [4:0]   op;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    int   busy_cnt   = 0;
    bit   chk_lat    = 1'b1;
    bit   rand_bp    = 1'b0;

    // Cycle counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    // Busy-cycle counter, sampled mid-cycle.
    always @(negedge clk) if (bus.busy) busy_cnt++;

    // Behavioural reference: plain arithmetic on widened operands.
    function automatic logic [W-1:0] model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] p;
        logic [63:0] ea, eb;
        case (op)
            C_AND:  return a & b;
            C_OR:   return a | b;
            C_XOR:  return a ^ b;
            C_ADD:  return a + b;
            C_SUB:  return a - b;
            C_SLL:  return a << b[4:0];
            C_SRL:  return a >> b[4:0];
            C_SRA:  return $unsigned($signed(a) >>> b[4:0]);
            C_EQ:   return (a == b) ? 32'd1 : 32'd0;
            C_NE:   return (a != b) ? 32'd1 : 32'd0;
            C_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            C_SLTU: return (a < b) ? 32'd1 : 32'd0;
            C_MUL: begin
                p = {32'b0, a} * {32'b0, b};
                return p[31:0];
            end
            C_MULH, C_MULHSU, C_MULHU: begin
                ea = (op != C_MULHU && a[31]) ? {32'hFFFF_FFFF, a} : {32'b0, a};
                eb = (op == C_MULH && b[31]) ? {32'hFFFF_FFFF, b} : {32'b0, b};
                p  = ea * eb;
                return p[63:32];
            end
            C_DIV: begin
                if (b == '0) return '1;
                if (a == MINV && b == '1) return a;
                return $unsigned($signed(a) / $signed(b));
            end
            C_DIVU: return (b == '0) ? '1 : a / b;
            C_REM: begin
                if (b == '0) return a;
                if (a == MINV && b == '1) return '0;
                return $unsigned($signed(a) % $signed(b));
            end
            C_REMU: return (b == '0) ? a : a % b;
            default: return '0;
        endcase
    endfunction

    function automatic int exp_latency(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        if (op < C_MUL || op > C_REMU) return 1;
        if (op >= C_DIV && b == '0) return 1;
        if ((op == C_DIV || op == C_REM) && a == MINV && b == '1) return 1;
        return W + 2;
    endfunction

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Present one operation, wait (bounded) for acceptance, then record its expected result.
    task automatic applyStimulus(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int   n;
        exp_t e;
        n = 0;
        bus.in_valid  = 1'b1;
        bus.Operation = op;
        bus.SrcA      = a;
        bus.SrcB      = b;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(posedge clk);
            #1;
            if (rand_bp) bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL accept_timeout op%02h: got in_ready 0 expected 1", op);
            bus.in_valid = 1'b0;
            return;
        end
        e.res     = model(op, a, b);
        e.lat     = chk_lat ? 32'(exp_latency(op, a, b)) : 32'd0;
        e.acc_cyc = 32'(cyc);
        e.op      = op;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.SrcA      = $urandom;
        bus.SrcB      = $urandom;
        bus.Operation = 5'($urandom_range(0, 31));
        if (rand_bp) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return MINV;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: compare every handed-over result against the head of the scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset_n && bus.out_valid && bus.out_ready && !bus.flush) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_output: got 0x%08h expected no result", bus.ALUResult);
            end else begin
                e = sb.pop_front();
                checkOutput($sformatf("result_op%02h", e.op), bus.ALUResult, e.res);
                checkOutput($sformatf("zero_op%02h", e.op), W'(bus.Zero), (e.res == '0) ? 32'd1 : 32'd0);
                if (e.lat != 0)
                    checkOutput($sformatf("latency_op%02h", e.op), 32'(cyc) - e.acc_cyc, e.lat);
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence of directed and randomized scenarios.
    initial begin
        logic [4:0]   codes [22];
        logic [W-1:0] bp_exp;
        int           start, n;

        codes = '{C_AND, C_OR, C_XOR, C_SRA, C_ADD, C_SUB, C_SLL, C_SRL, C_EQ, C_NE, C_SLT, C_SLTU,
                  C_MUL, C_MULH, C_MULHSU, C_MULHU, C_DIV, C_DIVU, C_REM, C_REMU, 5'b01100, 5'b11000};

        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        bus.Operation = '0;
        bus.SrcA      = '0;
        bus.SrcB      = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid", W'(bus.out_valid), 32'd0);
        checkOutput("rst_result", bus.ALUResult, 32'd0);
        checkOutput("rst_busy", W'(bus.busy), 32'd0);
        checkOutput("rst_in_ready", W'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_release_in_ready", W'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Reset in the middle of a divide discards everything.
        applyStimulus(C_DIV, 32'd1000, 32'd7);
        repeat (5) @(posedge clk);
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_out_valid", W'(bus.out_valid), 32'd0);
        checkOutput("midrst_result", bus.ALUResult, 32'd0);
        checkOutput("midrst_busy", W'(bus.busy), 32'd0);
        checkOutput("midrst_in_ready", W'(bus.in_ready), 32'd0);
        sb.delete();
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        checkOutput("midrst_release_in_ready", W'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Base ops streamed back to back.
        start = cyc;
        applyStimulus(C_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        applyStimulus(C_OR, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        applyStimulus(C_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        applyStimulus(C_SRA, 32'h8000_0000, 32'd4);
        applyStimulus(C_SLT, 32'hFFFF_FFFF, 32'd1);
        applyStimulus(C_SLTU, 32'hFFFF_FFFF, 32'd1);
        checkOutput("stream_rate", 32'(cyc - start), 32'd6);
        waitDrain();

        // Multiply with busy-duration measurement.
        busy_cnt = 0;
        applyStimulus(C_MUL, 32'd7, 32'hFFFF_FFFD);
        waitDrain();
        checkOutput("mul_busy_cycles", 32'(busy_cnt), 32'(W + 1));
        applyStimulus(C_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        applyStimulus(C_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Divide, remainder and the one-cycle special cases.
        applyStimulus(C_DIV, 32'hFFFF_FFF9, 32'd2);
        applyStimulus(C_REM, 32'hFFFF_FFF9, 32'd2);
        applyStimulus(C_DIVU, 32'd100, 32'd7);
        applyStimulus(C_REMU, 32'd100, 32'd7);
        applyStimulus(C_DIVU, 32'd5, 32'd0);
        applyStimulus(C_REM, 32'd5, 32'd0);
        applyStimulus(C_DIV, MINV, 32'hFFFF_FFFF);
        waitDrain();

        // Back-pressure: result held stable and no accept while out_ready is low.
        chk_lat       = 1'b0;
        bus.out_ready = 1'b0;
        bp_exp        = model(C_MUL, 32'h1234, 32'h5678);
        applyStimulus(C_MUL, 32'h1234, 32'h5678);
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("bp_out_valid", W'(bus.out_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp_result_held", bus.ALUResult, bp_exp);
            checkOutput("bp_in_ready", W'(bus.in_ready), 32'd0);
            if (i < 2) @(negedge clk);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        chk_lat = 1'b1;
        waitDrain();

        // Flush mid-divide together with a new request.
        applyStimulus(C_DIV, 32'd12345, 32'd17);
        repeat (10) @(posedge clk);
        #1;
        bus.flush     = 1'b1;
        bus.in_valid  = 1'b1;
        bus.Operation = C_ADD;
        bus.SrcA      = 32'd1;
        bus.SrcB      = 32'd2;
        @(negedge clk);
        checkOutput("flush_in_ready", W'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("flush_out_valid", W'(bus.out_valid), 32'd0);
        checkOutput("flush_busy", W'(bus.busy), 32'd0);
        checkOutput("flush_idle_ready", W'(bus.in_ready), 32'd1);
        if (sb.size() != 0) void'(sb.pop_back());
        repeat (40) @(posedge clk);
        #1;
        applyStimulus(C_ADD, 32'hFFFF_FFFF, 32'd1);
        waitDrain();

        // Randomized operations with out_ready held high.
        for (int i = 0; i < 150; i++) begin
            n = $urandom_range(0, 21);
            applyStimulus(codes[n], rand_operand(), rand_operand());
        end
        waitDrain();

        // Randomized operations with random back-pressure.
        chk_lat = 1'b0;
        rand_bp = 1'b1;
        for (int i = 0; i < 100; i++) begin
            n = $urandom_range(0, 21);
            applyStimulus(codes[n], rand_operand(), rand_operand());
        end
        rand_bp       = 1'b0;
        bus.out_ready = 1'b1;
        waitDrain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised execute-stage ALU for the RISC-V pipeline, extending the base integer operations with the M-extension (multiply, high multiply, divide, remainder). Base operations complete in one cycle. MUL*/DIV*/REM* run on an iterative radix-2 datapath over DATA_WIDTH cycles. A valid/ready handshake on both sides lets the hazard unit stall the pipeline while a long operation is in flight.

## Interface
- DATA_WIDTH, 32: operand/result width; power of two, ≥8
- OPCODE_LENGTH, 5: Operation field width
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  synchronous active-low reset
- in_valid  in  1  operands/Operation valid
- in_ready  out  1  block accepts a new operation this cycle
- SrcA, SrcB  in  DATA_WIDTH  operands, sampled on accept
- Operation  in  OPCODE_LENGTH  operation code, sampled on accept
- flush  in  1  synchronous abort of in-flight operation
- out_valid  out  1  ALUResult valid
- out_ready  in  1  consumer takes result
- ALUResult  out  DATA_WIDTH  registered result
- Zero  out  1  ALUResult == 0; meaningful only while out_valid
- busy  out  1  iterative operation in progress

## Operation
- Codes: 00000 AND, 00001 OR, 00010 XOR, 00100 ADD, 00101 SUB, 00110 SLL, 00111 SRL, 00011 SRA, 01000 EQ, 01001 NE, 01010 SLT, 01011 SLTU.
- Codes (continued): 10000 MUL, 10001 MULH, 10010 MULHSU, 10011 MULHU, 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU.
- Any other code: single-cycle result 0.
- Arithmetic wraps modulo 2^DATA_WIDTH.
- Shift amount is SrcB[log2(DATA_WIDTH)-1:0].
- Compare ops return 1 or 0, zero-extended.
- MUL returns the low half of the 2·DATA_WIDTH product; MULH*, the high half.
- Signedness: MULH signed×signed; MULHSU signed SrcA × unsigned SrcB; MULHU unsigned×unsigned.
- DIV/REM are signed with truncation toward zero; the remainder takes the sign of the dividend.
- Divide special cases resolve in one cycle, without iteration:
  - Divisor 0: DIV/DIVU return all-ones; REM/REMU return SrcA.
  - Signed overflow (SrcA = most-negative, SrcB = −1): DIV returns SrcA; REM returns 0.
- Iterative datapath: operands are converted to magnitudes on accept, then run DATA_WIDTH shift-add or restoring-subtract steps, then sign correction.
- State machine:
  - IDLE: accept → DONE (single-cycle op or divide special case), or → CALC (other M op).
  - CALC: counter runs DATA_WIDTH−1 down to 0; at 0 → FIX.
  - FIX: sign correction and result select → DONE.
  - DONE: if out_ready → IDLE, or directly re-accept when in_valid.
- in_ready = (IDLE | (DONE & out_ready)) & !flush & reset_n.
- busy = CALC | FIX.
- out_valid = DONE.

## Timing
- Reset (reset_n low at an edge): state IDLE, out_valid 0, ALUResult 0, counter 0, busy 0. in_ready is 0 while reset_n is low and 1 in the following cycle. Reset mid-operation discards all state.
- Accept happens on the edge where in_valid & in_ready.
- Single-cycle ops: out_valid is high in the cycle after accept (latency 1). Back-to-back accepts sustain 1 op/cycle while out_ready is held 1.
- Iterative ops: out_valid is high DATA_WIDTH+2 cycles after accept (34 at default width). in_ready stays 0 throughout CALC and FIX.
- Back-pressure: in DONE with out_ready 0, ALUResult and Zero are held stable and no new accept occurs.
- flush at an edge: state → IDLE, out_valid 0 next cycle, the result is discarded. flush takes priority over simultaneous in_valid (not accepted) and over out_ready.
- Changes on SrcA, SrcB and Operation after accept have no effect.

## Test plan
- Reset: hold reset_n low 2 cycles mid-DIV → out_valid 0, ALUResult 0, busy 0; in_ready 1 the cycle after release.
- Base ops: AND, OR and XOR of 0xF0F0F0F0, 0x0FF00FF0 → 0x00F000F0, 0xFFF0FFF0, 0xFF00FF00. SRA 0x80000000 by 4 → 0xF8000000. SLT −1 vs 1 → 1; SLTU → 0. Each has latency 1 and streams 1/cycle.
- Multiply: MUL 7 × −3 → 0xFFFFFFEB, out_valid exactly 34 cycles after accept, busy high 33 cycles. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH −1 × −1 → 0.
- Divide: DIV −7 / 2 → 0xFFFFFFFD; REM −7 / 2 → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2. Latency 34 for all.
- Special cases: DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000 / −1 → 0x80000000. All have latency 1.
- Handshake and flush: out_ready held 0 for 3 cycles after MUL completes → result stable, in_ready 0. flush asserted 10 cycles into DIV together with in_valid → IDLE next cycle, no out_valid for the DIV, the new op is not accepted.
